// File: rtl/mq_4bit_if.sv
// Handshake bundle for the mq_4bit partial-product stage (operand side and result side).
// Carries mq_parity only when MQ_4BIT_PARITY_EN is defined.
interface mq_4bit_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] m;
    logic             q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] mq;
    logic             mq_zero;
`ifdef MQ_4BIT_PARITY_EN
    logic             mq_parity;
`endif

    // Stage side: consumes operands and out_ready, produces the held result.
    modport slave (
        input  in_valid,
        input  m,
        input  q,
        input  out_ready,
        output in_ready,
        output out_valid,
        output mq,
`ifdef MQ_4BIT_PARITY_EN
        output mq_parity,
`endif
        output mq_zero
    );

    // Environment side: sequencer upstream plus adder row downstream.
    modport master (
        output in_valid,
        output m,
        output q,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  mq,
`ifdef MQ_4BIT_PARITY_EN
        input  mq_parity,
`endif
        input  mq_zero
    );
endinterface

// File: rtl/mq_4bit.sv
// Registered partial-product row (mq = m AND q) with a single-entry valid/ready stage.
// Optional registered parity output enabled by the MQ_4BIT_PARITY_EN macro.
module mq_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    mq_4bit_if.slave    bus
);
    logic             r_out_valid;
    logic [WIDTH-1:0] r_mq;
    logic             r_mq_zero;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_mq_next;

    // Full-throughput buffering: the slot frees in the same cycle it drains.
    always_comb begin
        w_in_ready = !r_out_valid || bus.out_ready;
        w_accept   = bus.in_valid && w_in_ready;
        w_mq_next  = bus.m & {WIDTH{bus.q}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_mq        <= '0;
            r_mq_zero   <= 1'b1;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_mq        <= w_mq_next;
            r_mq_zero   <= !bus.q || (bus.m == '0);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MQ_4BIT_PARITY_EN
    logic r_mq_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mq_parity <= 1'b0;
        end else if (w_accept) begin
            r_mq_parity <= ^w_mq_next;
        end
    end

    assign bus.mq_parity = r_mq_parity;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.mq        = r_mq;
    assign bus.mq_zero   = r_mq_zero;
endmodule

// File: tb/tb_mq_4bit.sv
// Self-checking bench for mq_4bit: directed vector table, async-reset sequence, random vs model.
module tb_mq_4bit;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mq_4bit_if #(.WIDTH(W)) bus ();

    mq_4bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [W-1:0] m;
        logic         q;
        logic         ordy;
        logic         rdy;
        logic         ov;
        logic [W-1:0] mq;
        logic         z;
        logic         par;
    } vec_t;

    // Reference model: the held result as a plain value computed by multiplication.
    logic         mdl_valid;
    logic [W-1:0] mdl_mq;
    logic         mdl_zero;
    logic         mdl_par;

    task automatic model_reset();
        mdl_valid = 1'b0;
        mdl_mq    = '0;
        mdl_zero  = 1'b1;
        mdl_par   = 1'b0;
    endtask

    task automatic model_edge(input logic iv, input logic [W-1:0] mm, input logic qq, input logic ordy);
        int prod;
        if (iv && (!mdl_valid || ordy)) begin
            prod      = int'(mm) * int'(qq);
            mdl_valid = 1'b1;
            mdl_mq    = W'(prod);
            mdl_zero  = (prod == 0);
            mdl_par   = ($countones(prod) % 2) == 1;
        end else if (ordy) begin
            mdl_valid = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] mm, input logic qq, input logic ordy);
        bus.in_valid  = iv;
        bus.m         = mm;
        bus.q         = qq;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic ov, input logic [W-1:0] mq,
                                 input logic z, input logic par);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, "_mq"},        32'(bus.mq),        32'(mq));
        chk({tag, "_mq_zero"},   32'(bus.mq_zero),   32'(z));
`ifdef MQ_4BIT_PARITY_EN
        chk({tag, "_mq_parity"}, 32'(bus.mq_parity), 32'(par));
`else
        if (par === 1'bx) n_checks = n_checks + 0;
`endif
    endtask

    vec_t tbl[14];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        bus.in_valid  = 1'b0;
        bus.m         = '0;
        bus.q         = 1'b0;
        bus.out_ready = 1'b0;

        //          iv  m        q     ordy  rdy   ov    mq       z     par
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};

        // Reset state while held
        rst = 1'b1;
        #2;
        check_outputs("reset", 1'b0, 4'b0000, 1'b1, 1'b0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: back-to-back accepts, stall, accept on release, drain, parity
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].iv, tbl[i].m, tbl[i].q, tbl[i].ordy);
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            model_edge(tbl[i].iv, tbl[i].m, tbl[i].q, tbl[i].ordy);
            #1;
            check_outputs($sformatf("vec%0d", i), tbl[i].ov, tbl[i].mq, tbl[i].z, tbl[i].par);
        end

        // Async reset between edges while holding 1111
        drive(1'b1, 4'b1111, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("pre_rst", 1'b1, 4'b1111, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 1'b0, 4'b0000, 1'b1, 1'b0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_rst_idle", 1'b0, 4'b0000, 1'b1, 1'b0);

        // Cold start after reset
        drive(1'b1, 4'b1001, 1'b1, 1'b0);
        chk("cold_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        model_edge(1'b1, 4'b1001, 1'b1, 1'b0);
        #1;
        check_outputs("cold", 1'b1, 4'b1001, 1'b0, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic         iv;
            logic [W-1:0] mm;
            logic         qq;
            logic         ordy;
            iv   = ($urandom_range(0, 3) != 0);
            mm   = W'($urandom);
            qq   = 1'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            drive(iv, mm, qq, ordy);
            chk("rand_in_ready", 32'(bus.in_ready), 32'(!mdl_valid || ordy));
            @(posedge clk);
            model_edge(iv, mm, qq, ordy);
            #1;
            check_outputs("rand", mdl_valid, mdl_mq, mdl_zero, mdl_par);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mq_4bit.md
Name: mq_4bit

Overview:
- Registered partial-product row generator for a 4-bit array/shift-add multiplier: outputs the 4-bit multiplicand `m` gated by a single multiplier bit `q`, i.e. `mq = m AND {4{q}}`.
- Single-entry pipeline stage with valid/ready handshake.
- Sits between operand sequencing logic and the adder row of the multiplier datapath.

Parameters:
- WIDTH, 4, multiplicand and partial-product width. The module name reflects the default. All behaviour below holds for any WIDTH ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  `m`/`q` carry a new operand pair this cycle.
- in_ready  output  1  stage can accept an operand pair this cycle.
- m  input  WIDTH  multiplicand.
- q  input  1  multiplier bit.
- out_valid  output  1  `mq` holds a valid partial product.
- out_ready  input  1  downstream accepts `mq` this cycle.
- mq  output  WIDTH  registered partial product `m & {WIDTH{q}}`.
- mq_zero  output  1  registered flag, high when the held `mq` equals 0.

Behaviour:
- Reset (`rst` = 1, asynchronous, takes effect immediately without a clock edge): `out_valid` = 0, `mq` = 0, `mq_zero` = 1. `in_ready` reflects the cleared state, so it is 1 while reset is held.
- `in_ready` = `!out_valid || out_ready`. This is combinational and gives full-throughput single-entry buffering.
- Accept: on a rising edge with `in_valid && in_ready`, the stage loads:
  - `mq` <= `m & {WIDTH{q}}` (bitwise AND of each `m` bit with `q`)
  - `mq_zero` <= (`q` == 0) OR (`m` == 0)
  - `out_valid` <= 1
- Latency: exactly 1 cycle from acceptance to `out_valid`/`mq`.
- Drain: on an edge with `out_valid && out_ready && !in_valid`, `out_valid` <= 0. `mq` and `mq_zero` hold their last values; they are don't-care when invalid, but must not glitch.
- Simultaneous drain and accept (`out_valid`, `out_ready`, `in_valid` all 1): the new operand pair replaces the output in the same edge and `out_valid` stays 1. No bubble.
- Stall (`out_valid && !out_ready`): `in_ready` = 0, inputs are ignored, and `mq`/`mq_zero`/`out_valid` hold.
- Changes on `m`/`q` while `in_valid` = 0 have no effect on outputs.
- No arithmetic carry or sign handling. Output width equals WIDTH exactly.
- Reset asserted mid-transfer discards any held result. After release, the first accepted pair behaves as from cold start.

Optional Feature:
- Macro: MQ_4BIT_PARITY_EN.
- Defined: adds output port `mq_parity` (1 bit), registered alongside `mq` on acceptance as the XOR-reduction of the new `mq`. It resets to 0 and holds on stall/drain.
- Undefined: the port does not exist, and no parity logic is present. All other behaviour is identical.

Test Plan:
- Reset, then accept `m`=0000, `q`=0 with `out_ready`=1 -> next cycle `out_valid`=1, `mq`=0000, `mq_zero`=1.
- Accept, one per cycle back-to-back, the sequence `m`=1111/`q`=0, 0000/1, 1111/1, 0101/1 -> `mq` in consecutive cycles = 0000, 0000, 1111, 0101, with `mq_zero` = 1, 1, 0, 0 and `out_valid` continuously 1. With MQ_4BIT_PARITY_EN defined, `mq_parity` = 0, 0, 0, 0.
- Accept `m`=1010/`q`=1, then hold `out_ready`=0 for 3 cycles while driving `m`=1111/`q`=1 with `in_valid`=1 -> `in_ready`=0, `mq` stays 1010. When `out_ready`=1, 1111 is accepted on that edge and appears the next cycle.
- `out_valid`=1 and `in_valid`=0 with `out_ready`=1 -> `out_valid` falls next cycle, and `in_ready`=1 throughout.
- Assert `rst` between edges while `mq`=1111 and `out_valid`=1 -> `out_valid`=0, `mq`=0000, `mq_zero`=1 immediately, before any clock edge.
- With MQ_4BIT_PARITY_EN defined, accept `m`=0111/`q`=1 -> `mq`=0111, `mq_parity`=1. Then accept `m`=0111/`q`=0 -> `mq_parity`=0.
